// File: rtl/chacha_stream_xor_if.sv
// Word stream bundle for chacha_stream_xor: input words in, XORed words out.
// A word moves on a channel only in a cycle where valid && ready; valid must hold
// (with data stable) until that cycle, and ready may depend combinationally on valid.
interface chacha_stream_xor_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/chacha_stream_xor.sv
// ChaCha20 keystream generator XORed onto a 32-bit valid/ready word stream,
// one registered 512-bit block at a time with automatic block-counter advance.
module chacha_stream_xor #(
   parameter bit CTR_INIT_ALLOW_WRAP = 1'b0,
   parameter int OUT_REG             = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [255:0]       key,
   input  logic [95:0]        nonce,
   input  logic [31:0]        ctr_init,
   output logic               busy,
   output logic               err,
   output logic [1:0]         state_dbg,
   chacha_stream_xor_if.slave s
);

   typedef enum logic [1:0] {IDLE = 2'd0, GEN = 2'd1, STREAM = 2'd2, ERR = 2'd3} state_t;

   state_t         state, state_nx;
   logic [255:0]   key_r;
   logic [95:0]    nonce_r;
   logic [31:0]    ctr_r;
   logic [511:0]   ks_r;
   logic [3:0]     word_idx;
   logic           out_valid_r, out_last_r, err_r;
   logic [31:0]    out_data_r;
   logic [511:0]   state_in, block_out;
   logic [31:0]    ks_word;
   logic           in_ready_c, accept, load_start, ctr_inc, set_err, out_full;

   function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
      logic [31:0] a, b, c, d;
      a = a_i; b = b_i; c = c_i; d = d_i;
      a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
      c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
      a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
      c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
      return {d, c, b, a};
   endfunction

   // Ten double rounds (column then diagonal), followed by the feed-forward add.
   function automatic logic [511:0] chacha_block(input logic [511:0] st);
      logic [31:0]  x [16];
      logic [511:0] r;
      for (int i = 0; i < 16; i++) x[i] = st[i*32 +: 32];
      for (int rd = 0; rd < 10; rd++) begin
         for (int c = 0; c < 4; c++)
            {x[12+c], x[8+c], x[4+c], x[c]} = qr(x[c], x[4+c], x[8+c], x[12+c]);
         for (int c = 0; c < 4; c++)
            {x[12+(c+3)%4], x[8+(c+2)%4], x[4+(c+1)%4], x[c]} =
               qr(x[c], x[4+(c+1)%4], x[8+(c+2)%4], x[12+(c+3)%4]);
      end
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i] + st[i*32 +: 32];
      return r;
   endfunction

   assign state_in  = {nonce_r, ctr_r, key_r,
                       32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
   assign block_out = chacha_block(state_in);
   assign ks_word   = ks_r[{word_idx, 5'd0} +: 32];

   // With a registered output, a new word fits only if the held one leaves this cycle.
   assign out_full = out_valid_r && (OUT_REG != 0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      in_ready_c = 1'b0;
      accept     = 1'b0;
      load_start = 1'b0;
      ctr_inc    = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE, ERR: begin
            if (start) begin
               load_start = 1'b1;
               state_nx   = GEN;
            end
         end
         GEN: state_nx = STREAM;
         STREAM: begin
            in_ready_c = !out_full || s.out_ready;
            accept     = s.in_valid && in_ready_c;
            if (accept) begin
               if (s.in_last) begin
                  state_nx = IDLE;
               end else if (word_idx == 4'd15) begin
                  if (ctr_r != 32'hFFFF_FFFF || CTR_INIT_ALLOW_WRAP) begin
                     ctr_inc  = 1'b1;
                     state_nx = GEN;
                  end else begin
                     set_err  = 1'b1;
                     state_nx = ERR;
                  end
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_r       <= '0;
         nonce_r     <= '0;
         ctr_r       <= '0;
         ks_r        <= '0;
         word_idx    <= '0;
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
      end else begin
         if (load_start) begin
            key_r   <= key;
            nonce_r <= nonce;
            ctr_r   <= ctr_init;
            err_r   <= 1'b0;
         end else if (ctr_inc) begin
            ctr_r <= ctr_r + 32'd1;
         end
         if (set_err) err_r <= 1'b1;
         if (state == GEN) begin
            ks_r     <= block_out;
            word_idx <= '0;
         end
         // Load and drain in the same cycle keep out_valid high.
         if (accept) begin
            out_data_r  <= s.in_data ^ ks_word;
            out_last_r  <= s.in_last;
            out_valid_r <= 1'b1;
            word_idx    <= word_idx + 4'd1;
         end else if (s.out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign s.in_ready  = in_ready_c;
   assign s.out_valid = out_valid_r;
   assign s.out_data  = out_data_r;
   assign s.out_last  = out_last_r;
   assign busy        = (state != IDLE);
   assign err         = err_r;
   assign state_dbg   = state;

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor against the published all-zero ChaCha20
// keystream blocks for counters 0 and 1.
module tb_chacha_stream_xor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         sel = 1'b0;
   logic         start = 1'b0;
   logic [255:0] key = '0;
   logic [95:0]  nonce = '0;
   logic [31:0]  ctr_init = '0;
   logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0]  in_data = '0;

   chacha_stream_xor_if bus0();
   chacha_stream_xor_if bus1();

   assign bus0.in_valid  = in_valid & ~sel;
   assign bus0.in_data   = in_data;
   assign bus0.in_last   = in_last;
   assign bus0.out_ready = out_ready & ~sel;
   assign bus1.in_valid  = in_valid & sel;
   assign bus1.in_data   = in_data;
   assign bus1.in_last   = in_last;
   assign bus1.out_ready = out_ready & sel;

   logic       busy0, err0, busy1, err1;
   logic [1:0] dbg0, dbg1;

   chacha_stream_xor #(.CTR_INIT_ALLOW_WRAP(1'b0), .OUT_REG(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .key(key), .nonce(nonce),
      .ctr_init(ctr_init), .busy(busy0), .err(err0), .state_dbg(dbg0), .s(bus0));

   chacha_stream_xor #(.CTR_INIT_ALLOW_WRAP(1'b1), .OUT_REG(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .key(key), .nonce(nonce),
      .ctr_init(ctr_init), .busy(busy1), .err(err1), .state_dbg(dbg1), .s(bus1));

   logic        w_in_ready, w_out_valid, w_out_last, w_busy, w_err;
   logic [31:0] w_out_data;
   logic [1:0]  w_state;
   assign w_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
   assign w_out_valid = sel ? bus1.out_valid : bus0.out_valid;
   assign w_out_data  = sel ? bus1.out_data  : bus0.out_data;
   assign w_out_last  = sel ? bus1.out_last  : bus0.out_last;
   assign w_busy      = sel ? busy1 : busy0;
   assign w_err       = sel ? err1  : err0;
   assign w_state     = sel ? dbg1  : dbg0;

   // All-zero key and nonce; counter 0 and counter 1 keystream words.
   logic [31:0] ks0 [16] = '{32'hade0b876, 32'h903df1a0, 32'he56a5d40, 32'h28bd8653,
                             32'hb819d2bd, 32'h1aed8da0, 32'hccef36a8, 32'hc70d778b,
                             32'h7c5941da, 32'h8d485751, 32'h3fe02477, 32'h374ad8b8,
                             32'hf4b8436a, 32'h1ca11815, 32'h69b687c3, 32'h8665eeb2};
   logic [31:0] ks1 [16] = '{32'hbee7079f, 32'h7a385155, 32'h7c97ba98, 32'h0d082d73,
                             32'ha0290fcb, 32'h6965e348, 32'h3e53c612, 32'hed7aee32,
                             32'h7621b729, 32'h434ee69c, 32'hb03371d5, 32'hd539d874,
                             32'h281fed31, 32'h45fb0a51, 32'h1f0ae1ac, 32'h6f4d794b};

   logic [31:0] exp_q [$];
   logic [31:0] got_q [$];
   logic        got_last_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          sent;
   int          hold_viol;
   logic [31:0] pat_add = '0, pat_mul = '0;

   function automatic logic [31:0] din(input int i);
      return pat_add ^ (pat_mul * 32'(i));
   endfunction

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.delete(); got_q.delete(); got_last_q.delete();
   endtask

   task automatic pulse_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      key = k; nonce = n; ctr_init = c; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_stream(input int n, input int last_at, input bit toggle, input int base);
      int   cyc = 0;
      bit   acc;
      bit   held_v = 1'b0;
      logic [31:0] held = '0;
      sent = 0;
      hold_viol = 0;
      while (sent < n && cyc < 200) begin
         in_valid  = 1'b1;
         in_data   = din(base + sent);
         in_last   = (sent + 1 == last_at);
         out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
         @(negedge clk);
         if (held_v && (!w_out_valid || w_out_data !== held)) hold_viol++;
         if (w_out_valid && out_ready) begin
            got_q.push_back(w_out_data);
            got_last_q.push_back(w_out_last);
         end
         held_v = w_out_valid && !out_ready;
         held   = w_out_data;
         acc    = in_valid && w_in_ready;
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (w_out_valid) begin
            got_q.push_back(w_out_data);
            got_last_q.push_back(w_out_last);
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", w_busy); end
      n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b want=0", w_err); end
      n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", w_in_ready); end
      n_checks++; if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", w_out_valid); end
      n_checks++; if (w_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", w_out_data); end
      n_checks++; if (w_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got=%b want=0", w_out_last); end
      n_checks++; if (w_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", w_state); end
   endtask

   task automatic test_keystream_block();
      apply_reset();
      pat_add = '0; pat_mul = '0;
      pulse_start('0, '0, 32'd0);
      n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL ks_gen_in_ready got=%b want=0", w_in_ready); end
      n_checks++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL ks_gen_busy got=%b want=1", w_busy); end
      @(posedge clk); #1;
      n_checks++; if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL ks_first_ready got=%b want=1", w_in_ready); end
      run_stream(16, 0, 1'b0, 0);
      n_checks++; if (sent !== 16) begin n_fail++; $display("FAIL ks_sent got=%0d want=16", sent); end
      n_checks++; if (w_in_ready !== 1'b0 || w_state !== 2'd1) begin
         n_fail++; $display("FAIL ks_bubble in_ready=%b state=%0d want in_ready=0 state=1", w_in_ready, w_state); end
      run_stream(1, 1, 1'b0, 16);
      n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL ks_busy_fall got=%b want=0", w_busy); end
      drain();
      for (int i = 0; i < 16; i++) exp_q.push_back(ks0[i]);
      exp_q.push_back(ks1[0]);
      n_checks++; if (got_q.size() !== exp_q.size()) begin
         n_fail++; $display("FAIL ks_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL ks_word[%0d] got=%h want=%h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      pat_add = 32'hdeadbeef; pat_mul = 32'h01000193;
      pulse_start('0, '0, 32'd0);
      run_stream(16, 16, 1'b1, 0);
      n_checks++; if (sent !== 16) begin n_fail++; $display("FAIL bp_sent got=%0d want=16", sent); end
      drain();
      n_checks++; if (hold_viol !== 0) begin n_fail++; $display("FAIL bp_hold got=%0d want=0", hold_viol); end
      n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL bp_count got=%0d want=16", got_q.size()); end
      for (int i = 0; i < 16 && i < got_q.size(); i++) begin
         n_checks++; if (got_q[i] !== (ks0[i] ^ din(i))) begin
            n_fail++; $display("FAIL bp_word[%0d] got=%h want=%h", i, got_q[i], ks0[i] ^ din(i)); end
      end
   endtask

   task automatic check_twenty(input string tag);
      n_checks++; if (got_q.size() !== 20) begin
         n_fail++; $display("FAIL %s_count got=%0d want=20", tag, got_q.size()); end
      for (int i = 0; i < 20 && i < got_q.size(); i++) begin
         logic [31:0] e;
         e = (i < 16 ? ks0[i] : ks1[i-16]) ^ din(i);
         n_checks++; if (got_q[i] !== e || got_last_q[i] !== (i == 19)) begin
            n_fail++; $display("FAIL %s_word[%0d] got=%h/%b want=%h/%b", tag, i, got_q[i], got_last_q[i], e, i == 19); end
      end
   endtask

   task automatic test_long_message();
      apply_reset();
      pat_add = 32'h13579bdf; pat_mul = 32'h9e3779b9;
      pulse_start('0, '0, 32'd0);
      run_stream(20, 20, 1'b0, 0);
      n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL long_busy_fall got=%b want=0", w_busy); end
      drain();
      check_twenty("long");
   endtask

   task automatic test_midstream_start();
      apply_reset();
      pat_add = 32'h0badf00d; pat_mul = 32'h00010001;
      pulse_start('0, '0, 32'd0);
      fork
         run_stream(20, 20, 1'b0, 0);
         begin
            repeat (6) @(posedge clk);
            #2 start = 1'b1; key = '1; nonce = '1; ctr_init = 32'h55;
            @(posedge clk);
            #2 start = 1'b0;
         end
      join
      n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_fall got=%b want=0", w_busy); end
      drain();
      check_twenty("mid");
   endtask

   task automatic test_ctr_exhaust();
      int leaked = 0;
      apply_reset();
      pat_add = '0; pat_mul = '0;
      pulse_start('0, '0, 32'hffff_ffff);
      run_stream(16, 0, 1'b0, 0);
      n_checks++; if (sent !== 16) begin n_fail++; $display("FAIL exh_sent got=%0d want=16", sent); end
      n_checks++; if (w_err !== 1'b1) begin n_fail++; $display("FAIL exh_err got=%b want=1", w_err); end
      n_checks++; if (w_state !== 2'd3) begin n_fail++; $display("FAIL exh_state got=%0d want=3", w_state); end
      n_checks++; if (w_in_ready !== 1'b0) begin n_fail++; $display("FAIL exh_in_ready got=%b want=0", w_in_ready); end
      drain();
      n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL exh_count got=%0d want=16", got_q.size()); end
      in_valid = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (w_in_ready) leaked++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_checks++; if (leaked !== 0) begin n_fail++; $display("FAIL exh_word17_ready got=%0d want=0", leaked); end
      got_q.delete(); got_last_q.delete();
      pulse_start('0, '0, 32'd0);
      n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL exh_err_clear got=%b want=0", w_err); end
      n_checks++; if (w_busy !== 1'b1) begin n_fail++; $display("FAIL exh_restart_busy got=%b want=1", w_busy); end
      run_stream(1, 1, 1'b0, 0);
      drain();
      n_checks++; if (got_q.size() !== 1 || got_q[0] !== ks0[0]) begin
         n_fail++; $display("FAIL exh_restart_word got=%h (n=%0d) want=%h", got_q.size() > 0 ? got_q[0] : 32'h0, got_q.size(), ks0[0]); end
   endtask

   task automatic test_ctr_wrap();
      apply_reset();
      sel = 1'b1;
      pat_add = 32'h5a5a0000; pat_mul = 32'h00000101;
      pulse_start('0, '0, 32'hffff_ffff);
      run_stream(17, 17, 1'b0, 0);
      drain();
      n_checks++; if (got_q.size() !== 17) begin n_fail++; $display("FAIL wrap_count got=%0d want=17", got_q.size()); end
      if (got_q.size() == 17) begin
         n_checks++; if (got_q[16] !== (ks0[0] ^ din(16)) || got_last_q[16] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_word17 got=%h/%b want=%h/1", got_q[16], got_last_q[16], ks0[0] ^ din(16)); end
      end
      n_checks++; if (w_err !== 1'b0) begin n_fail++; $display("FAIL wrap_err got=%b want=0", w_err); end
      sel = 1'b0;
   endtask

   task automatic test_reset_midstream();
      apply_reset();
      pat_add = 32'h12345678; pat_mul = 32'h11111111;
      pulse_start('0, '0, 32'd0);
      run_stream(7, 0, 1'b0, 0);
      n_checks++; if (w_out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b want=1", w_out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({w_out_valid, w_out_last, w_busy, w_in_ready, w_err} !== 5'b0 || w_out_data !== 32'h0) begin
         n_fail++; $display("FAIL rst_async got v/l/b/r/e=%b data=%h want 00000/0",
                            {w_out_valid, w_out_last, w_busy, w_in_ready, w_err}, w_out_data); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      got_q.delete(); got_last_q.delete();
      pulse_start('0, '0, 32'd0);
      run_stream(1, 1, 1'b0, 0);
      drain();
      n_checks++; if (got_q.size() !== 1 || got_q[0] !== (ks0[0] ^ din(0))) begin
         n_fail++; $display("FAIL rst_fresh_word got=%h (n=%0d) want=%h", got_q.size() > 0 ? got_q[0] : 32'h0, got_q.size(), ks0[0] ^ din(0)); end
   endtask

   initial begin
      test_reset();
      test_keystream_block();
      test_backpressure();
      test_long_message();
      test_midstream_start();
      test_ctr_exhaust();
      test_ctr_wrap();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
